sha256_multicore_sched: RTL and testbench

- Batch scheduler for an array of NUM_CORES SHA256 compression cores that share one round counter and one Kt constant source.
- Accepts 512-bit blocks from the upstream assembler and loads them into consecutive idle cores.
- Runs the whole batch in lockstep for 64 rounds, then drains the digests to one output port in core-index order.
- Owns the 64-entry SHA-256 K ROM, the shared 6-bit round counter and per-core enable gating.

---
 rtl/sha256_multicore_sched_if.sv | 13 +
 rtl/sha256_multicore_sched.sv | 118 +++++++++++
 tb/tb_sha256_multicore_sched.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_multicore_sched_if.sv
// sha256_multicore_sched_if: upstream block handshake and downstream digest handshake of the scheduler.
interface sha256_multicore_sched_if #(parameter int NUM_CORES = 4);
  localparam int IW = $clog2(NUM_CORES);
  logic           v_i;
  logic [511:0]   msg_i;
  logic           ready_o;
  logic           v_o;
  logic [255:0]   digest_o;
  logic [IW-1:0]  id_o;
  logic           yumi_i;
  modport slave  (input v_i, msg_i, yumi_i, output ready_o, v_o, digest_o, id_o);
  modport master (output v_i, msg_i, yumi_i, input ready_o, v_o, digest_o, id_o);
endinterface

// File: rtl/sha256_multicore_sched.sv
// sha256_multicore_sched: lockstep batch scheduler for NUM_CORES SHA-256 cores sharing one round counter and K ROM.
// Define SHA256_SCHED_PERF_EN to add batch_cnt_o/msg_cnt_o performance counters.
module sha256_multicore_sched #(
  parameter int NUM_CORES = 4,
  parameter int IDLE_WAIT = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  sha256_multicore_sched_if.slave   bus,
  output logic [NUM_CORES-1:0]      core_en_o,
  output logic [NUM_CORES-1:0]      core_v_o,
  output logic [511:0]              core_msg_o,
  input  logic [NUM_CORES-1:0]      core_ready_i,
  input  logic [NUM_CORES-1:0]      core_v_i,
  output logic [NUM_CORES-1:0]      core_yumi_o,
  input  logic [256*NUM_CORES-1:0]  core_digest_i,
  output logic [31:0]               Kt_o,
  output logic [5:0]                core_ctr_o
`ifdef SHA256_SCHED_PERF_EN
  ,
  output logic [31:0]               batch_cnt_o,
  output logic [31:0]               msg_cnt_o
`endif
);
  localparam int CW = $clog2(NUM_CORES + 1);
  localparam int IW = $clog2(NUM_CORES);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  typedef enum logic [1:0] {eLoad, eRun, eDrain} state_e;
  state_e               r_state, w_state_n;
  logic [CW-1:0]        r_load_cnt, w_load_cnt_n;
  logic [IW-1:0]        r_drain_ptr, w_drain_ptr_n;
  logic [7:0]           r_idle_cnt, w_idle_cnt_n;
  logic [5:0]           r_round_ctr, w_round_ctr_n;
  logic [NUM_CORES-1:0] w_loaded;
  logic                 w_ready, w_acc, w_vo, w_pop, w_launch;
  always_comb
    for (int k = 0; k < NUM_CORES; k++) w_loaded[k] = k < int'(r_load_cnt);
  assign w_ready = r_state == eLoad && r_load_cnt < CW'(NUM_CORES) && core_ready_i[r_load_cnt[IW-1:0]];
  assign w_acc   = bus.v_i && w_ready;
  assign w_vo    = r_state == eDrain && core_v_i[r_drain_ptr];
  assign w_pop   = w_vo && bus.yumi_i;
  // Launch on the accept that fills the array so the run starts the very next cycle.
  assign w_launch = (w_acc && r_load_cnt == CW'(NUM_CORES - 1)) || r_load_cnt == CW'(NUM_CORES) ||
                    (r_load_cnt != '0 && !bus.v_i && r_idle_cnt == 8'(IDLE_WAIT - 1));
  assign bus.ready_o  = w_ready;
  assign bus.v_o      = w_vo;
  assign bus.id_o     = r_drain_ptr;
  assign bus.digest_o = w_vo ? core_digest_i[{r_drain_ptr, 8'd0} +: 256] : '0;
  assign core_msg_o   = bus.msg_i;
  assign core_v_o     = w_acc ? NUM_CORES'(1) << r_load_cnt : '0;
  assign core_en_o    = r_state == eLoad ? core_v_o : w_loaded;
  assign core_yumi_o  = w_pop ? NUM_CORES'(1) << r_drain_ptr : '0;
  assign Kt_o         = K[r_round_ctr];
  assign core_ctr_o   = r_round_ctr;
  always_comb begin
    w_state_n     = r_state;
    w_load_cnt_n  = r_load_cnt;
    w_drain_ptr_n = r_drain_ptr;
    w_idle_cnt_n  = r_idle_cnt;
    w_round_ctr_n = r_round_ctr;
    case (r_state)
      eLoad: begin
        w_load_cnt_n = w_acc ? r_load_cnt + CW'(1) : r_load_cnt;
        w_idle_cnt_n = (w_acc || w_launch) ? '0 : (r_load_cnt != '0 && !bus.v_i) ? r_idle_cnt + 8'd1 : r_idle_cnt;
        w_state_n    = w_launch ? eRun : eLoad;
      end
      eRun: begin
        w_round_ctr_n = r_round_ctr + 6'd1;
        w_state_n     = r_round_ctr == 6'd63 ? eDrain : eRun;
      end
      eDrain:
        if (w_pop) begin
          if (CW'(r_drain_ptr) == r_load_cnt - CW'(1)) begin
            w_state_n     = eLoad;
            w_load_cnt_n  = '0;
            w_drain_ptr_n = '0;
          end else w_drain_ptr_n = r_drain_ptr + IW'(1);
        end
      default: w_state_n = eLoad;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_state     <= eLoad;
      r_load_cnt  <= '0;
      r_drain_ptr <= '0;
      r_idle_cnt  <= '0;
      r_round_ctr <= '0;
    end else begin
      r_state     <= w_state_n;
      r_load_cnt  <= w_load_cnt_n;
      r_drain_ptr <= w_drain_ptr_n;
      r_idle_cnt  <= w_idle_cnt_n;
      r_round_ctr <= w_round_ctr_n;
    end
`ifdef SHA256_SCHED_PERF_EN
  logic [31:0] r_batch_cnt, r_msg_cnt;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_batch_cnt <= '0;
      r_msg_cnt   <= '0;
    end else begin
      r_batch_cnt <= (r_state == eLoad && w_launch) ? r_batch_cnt + 32'd1 : r_batch_cnt;
      r_msg_cnt   <= w_acc ? r_msg_cnt + 32'd1 : r_msg_cnt;
    end
  assign batch_cnt_o = r_batch_cnt;
  assign msg_cnt_o   = r_msg_cnt;
`endif
endmodule

// File: tb/tb_sha256_multicore_sched.sv
// tb_sha256_multicore_sched: drives the scheduler with four SHA-256 core models that round on core_en_o/Kt_o,
// and scores every digest against a one-shot SHA-256 reference.
module tb_sha256_multicore_sched;
  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 416'd0, 64'h18};
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [31:0] KB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  typedef logic [63:0][31:0] wv_t;
  typedef struct {logic [1:0] id; logic [255:0] dg;} exp_t;
  logic clk = 0;
  logic rst_n;
  logic [3:0] core_en_o, core_v_o, core_ready_i, core_v_i, core_yumi_o;
  logic [511:0] core_msg_o;
  logic [1023:0] core_digest_i;
  logic [31:0] Kt_o;
  logic [5:0] core_ctr_o;
`ifdef SHA256_SCHED_PERF_EN
  logic [31:0] batch_cnt_o, msg_cnt_o;
`endif
  int total = 0, bad = 0, npos = 0, nacc = 0, nbatch = 0, pops = 0, k;
  exp_t sq[$];
  exp_t e;
  logic acc, hs;
  logic [3:0] busy, done;
  logic [255:0] cst [4];
  wv_t cw [4];
  sha256_multicore_sched_if #(.NUM_CORES(4)) bus();
  sha256_multicore_sched #(.NUM_CORES(4), .IDLE_WAIT(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus),
    .core_en_o(core_en_o), .core_v_o(core_v_o), .core_msg_o(core_msg_o),
    .core_ready_i(core_ready_i), .core_v_i(core_v_i), .core_yumi_o(core_yumi_o),
    .core_digest_i(core_digest_i), .Kt_o(Kt_o), .core_ctr_o(core_ctr_o)
`ifdef SHA256_SCHED_PERF_EN
    , .batch_cnt_o(batch_cnt_o), .msg_cnt_o(msg_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic wv_t expand(input logic [511:0] m);
    wv_t w;
    for (int t = 0; t < 64; t++)
      w[t] = t < 16 ? m[511-32*t -: 32] :
             (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    return w;
  endfunction
  function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] kt, input logic [31:0] w);
    logic [31:0] a, b, c, d, f, g, h, x, t1, t2;
    {a, b, c, d, x, f, g, h} = s;
    t1 = h + (rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25)) + ((x & f) ^ (~x & g)) + kt + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, x, f, g};
  endfunction
  function automatic logic [255:0] addh(input logic [255:0] s);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = s[32*i +: 32] + H0[32*i +: 32];
    return r;
  endfunction
  function automatic logic [255:0] sha(input logic [511:0] m);
    wv_t w = expand(m);
    logic [255:0] s = H0;
    for (int t = 0; t < 64; t++) s = rnd(s, KB[t], w[t]);
    return addh(s);
  endfunction
  function automatic logic [511:0] mk(input int i);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = 32'(i * 16 + j) * 32'h9e3779b9;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Core models: load on start pulse, then one round per enabled cycle using the shared Kt_o and counter.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      done <= '0;
      for (int i = 0; i < 4; i++) cst[i] <= '0;
    end else
      for (int i = 0; i < 4; i++) begin
        if (core_v_o[i] && core_en_o[i]) begin
          cw[i] <= expand(core_msg_o);
          cst[i] <= H0;
          busy[i] <= 1'b1;
          done[i] <= 1'b0;
        end else if (core_en_o[i] && busy[i]) begin
          cst[i] <= core_ctr_o == 6'd63 ? addh(rnd(cst[i], Kt_o, cw[i][core_ctr_o])) : rnd(cst[i], Kt_o, cw[i][core_ctr_o]);
          if (core_ctr_o == 6'd63) begin
            busy[i] <= 1'b0;
            done[i] <= 1'b1;
          end
        end
        if (core_yumi_o[i]) done[i] <= 1'b0;
      end
  assign core_ready_i = ~(busy | done);
  assign core_v_i = done;
  always_comb
    for (int i = 0; i < 4; i++) core_digest_i[256*i +: 256] = cst[i];
  // Scoreboard: digests must leave in acceptance order, tagged with their batch position.
  always @(negedge clk)
    if (rst_n) begin
      chk("kt_rom", Kt_o, KB[core_ctr_o]);
      chk("msg_bcast", core_msg_o, bus.msg_i);
      if (!bus.v_o) chk("digest_zero", bus.digest_o, 0);
      if (core_ctr_o != 6'd0) chk("ready_in_run", bus.ready_o, 0);
      if (core_ctr_o == 6'd1) nbatch++;
      acc = bus.v_i && bus.ready_o;
      chk("core_v", core_v_o, acc ? 4'b1 << npos : 4'b0);
      if (acc) begin
        sq.push_back('{id: 2'(npos), dg: sha(bus.msg_i)});
        npos++;
        nacc++;
      end
      hs = bus.v_o && bus.yumi_i;
      if (bus.v_o) chk("vo_pending", sq.size() != 0, 1);
      chk("core_yumi", core_yumi_o, (hs && sq.size() != 0) ? 4'b1 << sq[0].id : 4'b0);
      if (hs && sq.size() != 0) begin
        e = sq.pop_front();
        chk("id", bus.id_o, e.id);
        chk("digest", bus.digest_o, e.dg);
        pops++;
        if (sq.size() == 0) npos = 0;
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end
  initial begin
    rst_n = 0;
    bus.v_i = 0;
    bus.msg_i = '0;
    bus.yumi_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_kt", Kt_o, 32'h428a2f98);
    chk("rst_ctr", core_ctr_o, 0);
    chk("rst_en", core_en_o, 0);
    chk("rst_vo", bus.v_o, 0);
    rst_n = 1;
    // full batch on cycles 0..3
    for (int i = 0; i < 4; i++) begin
      bus.v_i = 1;
      bus.msg_i = mk(i);
      #1;
      chk("t1_core_v", core_v_o, 4'b1 << i);
      chk("t1_core_en", core_en_o, 4'b1 << i);
      tick;
    end
    bus.v_i = 0;
    #1;
    chk("t1_run_en", core_en_o, 4'hf);
    chk("t1_ctr0", core_ctr_o, 0);
    chk("t1_kt0", Kt_o, 32'h428a2f98);
    repeat (63) tick;
    chk("t1_ctr63", core_ctr_o, 63);
    chk("t1_kt63", Kt_o, 32'hc67178f2);
    chk("t1_vo_early", bus.v_o, 0);
    tick;
    chk("t1_vo68", bus.v_o, 1);
    bus.yumi_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_id", bus.id_o, i);
      tick;
    end
    bus.yumi_i = 0;
    #1;
    chk("t1_back_ready", bus.ready_o, 1);
    // single "abc" block, partial-batch launch and stalled drain
    bus.v_i = 1;
    bus.msg_i = ABC;
    tick;
    bus.v_i = 0;
    repeat (3) tick;
    chk("t2_en_c4", core_en_o, 0);
    tick;
    chk("t2_en_c5", core_en_o, 4'b0001);
    chk("t2_ctr_c5", core_ctr_o, 0);
    repeat (63) tick;
    chk("t2_vo_c68", bus.v_o, 0);
    tick;
    chk("t2_vo_c69", bus.v_o, 1);
    chk("t2_abc", bus.digest_o, ABC_D);
    for (int i = 0; i < 10; i++) begin
      chk("t2_stall_vo", bus.v_o, 1);
      chk("t2_stall_id", bus.id_o, 0);
      chk("t2_stall_dg", bus.digest_o, ABC_D);
      chk("t2_stall_yumi", core_yumi_o, 0);
      chk("t2_stall_rdy", bus.ready_o, 0);
      tick;
    end
    bus.yumi_i = 1;
    tick;
    bus.yumi_i = 0;
    #1;
    chk("t2_ready", bus.ready_o, 1);
    chk("t2_vo_off", bus.v_o, 0);
    // upstream keeps a block valid through run and drain
    for (int i = 4; i < 8; i++) begin
      bus.v_i = 1;
      bus.msg_i = mk(i);
      tick;
    end
    bus.msg_i = mk(8);
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("t3_run_rdy", bus.ready_o, 0);
      chk("t3_run_cv", core_v_o, 0);
      tick;
    end
    bus.yumi_i = 1;
    k = 0;
    while (!bus.ready_o && k < 20) begin
      tick;
      k++;
    end
    chk("t3_ready", bus.ready_o, 1);
    chk("t3_accept", core_v_o, 4'b0001);
    tick;
    bus.v_i = 0;
    k = 0;
    while (sq.size() != 0 && k < 300) begin
      tick;
      k++;
    end
    chk("t3_drained", sq.size(), 0);
    bus.yumi_i = 0;
`ifdef SHA256_SCHED_PERF_EN
    chk("perf_batch", batch_cnt_o, 4);
    chk("perf_msg", msg_cnt_o, 10);
`endif
    // reset in the middle of a run
    for (int i = 9; i < 11; i++) begin
      bus.v_i = 1;
      bus.msg_i = mk(i);
      tick;
    end
    bus.v_i = 0;
    k = 0;
    while (core_ctr_o != 6'd30 && k < 200) begin
      tick;
      k++;
    end
    chk("t4_ctr30", core_ctr_o, 30);
    rst_n = 0;
    #1;
    chk("t4_ctr", core_ctr_o, 0);
    chk("t4_ready", bus.ready_o, 1);
    chk("t4_en", core_en_o, 0);
    chk("t4_kt", Kt_o, 32'h428a2f98);
    chk("t4_vo", bus.v_o, 0);
    chk("t4_cv", core_v_o, 0);
    sq.delete();
    npos = 0;
    nacc = 0;
    nbatch = 0;
    tick;
    rst_n = 1;
    bus.v_i = 1;
    bus.msg_i = ABC;
    tick;
    bus.v_i = 0;
    bus.yumi_i = 1;
    k = 0;
    while (sq.size() != 0 && k < 300) begin
      tick;
      k++;
    end
    chk("t4_drained", sq.size(), 0);
    bus.yumi_i = 0;
    tick;
    chk("pops", pops, 11);
`ifdef SHA256_SCHED_PERF_EN
    chk("perf_batch_rst", batch_cnt_o, nbatch);
    chk("perf_msg_rst", msg_cnt_o, nacc);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
